// File: rtl/exc_pkg.sv
// Shared types and cause codes for the exception controller.
package exc_pkg;

    localparam int unsigned MAX_IRQ = 8;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StHandler
    } exc_state_e;

    localparam logic [3:0] CAUSE_NONE     = 4'b0000;
    localparam logic [3:0] CAUSE_INVOP    = 4'b0010;
    localparam logic [3:0] CAUSE_EXT_BASE = 4'b1000;

    function automatic logic [3:0] ext_cause(input logic [2:0] ch);
        return CAUSE_EXT_BASE | {1'b0, ch};
    endfunction

endpackage

// File: rtl/irq_edge_pend.sv
// One interrupt channel: input register, rising-edge detect and pending flag.
module irq_edge_pend (
    input  logic clk,
    input  logic reset_n,
    input  logic irq,
    input  logic clr,
    output logic pending
);

    logic irq_q;
    logic armed_q;
    logic pend_q;
    logic irq_rise;

    // armed_q blocks a level held high through reset release from looking like a rise
    assign irq_rise = irq & ~irq_q & armed_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_q   <= 1'b0;
            armed_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            irq_q   <= irq;
            armed_q <= armed_q | ~irq;
            pend_q  <= irq_rise | (pend_q & ~clr);
        end
    end

    assign pending = pend_q;

endmodule

// File: rtl/exception_ctrl.sv
// Exception controller: arbitrates invalid-opcode and external interrupts into one request.
// Optional per-channel mask register is enabled with `define EXC_IRQ_MASK_EN.
module exception_ctrl
    import exc_pkg::*;
#(
    parameter int unsigned N_IRQ = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_IRQ-1:0] irq,
    input  logic             not_an_instr,
    input  logic             eret,
    input  logic             exc_ack,
`ifdef EXC_IRQ_MASK_EN
    input  logic             irq_mask_we,
    input  logic [N_IRQ-1:0] irq_mask_wdata,
`endif
    output logic             exc,
    output logic [3:0]       estatus,
    output logic [N_IRQ-1:0] irq_ack,
    output logic             in_handler
);

    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] enable;
    logic [N_IRQ-1:0] clr;
    exc_state_e       state_q, state_d;
    logic [3:0]       cause_q, cause_d;
    logic             win_found;
    logic [$clog2(MAX_IRQ)-1:0] win_idx;

`ifdef EXC_IRQ_MASK_EN
    logic [N_IRQ-1:0] mask_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q <= '1;
        end else if (irq_mask_we) begin
            mask_q <= irq_mask_wdata;
        end
    end

    assign enable = mask_q;
`else
    assign enable = '1;
`endif

    for (genvar g = 0; g < N_IRQ; g++) begin : g_ch
        irq_edge_pend u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .irq     (irq[g]),
            .clr     (clr[g]),
            .pending (pending[g])
        );
    end

    // Lowest enabled pending channel wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < int'(N_IRQ); i++) begin
            if (!win_found && pending[i] && enable[i]) begin
                win_found = 1'b1;
                win_idx   = 3'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        irq_ack = '0;
        unique case (state_q)
            StIdle: begin
                if (not_an_instr) begin
                    state_d = StReq;
                    cause_d = CAUSE_INVOP;
                end else if (win_found) begin
                    state_d = StReq;
                    cause_d = ext_cause(win_idx);
                end
            end
            StReq: begin
                if (exc_ack) begin
                    state_d = StHandler;
                    for (int i = 0; i < int'(N_IRQ); i++) begin
                        irq_ack[i] = cause_q[3] && (cause_q[2:0] == 3'(i));
                    end
                end
            end
            StHandler: begin
                if (eret) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign clr = irq_ack;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    assign exc        = (state_q == StReq);
    assign in_handler = (state_q == StHandler);
    assign estatus    = (state_q == StIdle) ? CAUSE_NONE : cause_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// Scoreboard bench for exception_ctrl: directed scenarios plus random traffic vs a reference model.
module tb_exception_ctrl;

    localparam int N = 4;

    typedef struct packed {
        logic         exc;
        logic [3:0]   est;
        logic [N-1:0] ack;
        logic         inh;
    } obs_t;

    logic         clk, reset_n, nai, eret, exc_ack, mwe;
    logic [N-1:0] irq, mwd;
    logic         exc, in_handler;
    logic [3:0]   estatus;
    logic [N-1:0] irq_ack;

    obs_t sb[$];
    int   total  = 0;
    int   passed = 0;

    // Reference model: mode 0 idle, 1 requesting, 2 in handler.
    int           mode, cause;
    logic [N-1:0] m_pend, m_prev, m_armed, m_mask;

    exception_ctrl #(.N_IRQ(N)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .irq            (irq),
        .not_an_instr   (nai),
        .eret           (eret),
        .exc_ack        (exc_ack),
`ifdef EXC_IRQ_MASK_EN
        .irq_mask_we    (mwe),
        .irq_mask_wdata (mwd),
`endif
        .exc            (exc),
        .estatus        (estatus),
        .irq_ack        (irq_ack),
        .in_handler     (in_handler)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        mode    = 0;
        cause   = 0;
        m_pend  = '0;
        m_prev  = '0;
        m_armed = '0;
        m_mask  = '1;
    endtask

    task automatic model_step();
        logic [N-1:0] rise;
        int w;
        if (!reset_n) begin
            model_reset();
            return;
        end
        rise = irq & ~m_prev & m_armed;
        case (mode)
            0: begin
                if (nai) begin
                    mode  = 1;
                    cause = 2;
                end else begin
                    w = -1;
                    for (int c = N - 1; c >= 0; c--) if (m_pend[c] && m_mask[c]) w = c;
                    if (w >= 0) begin
                        mode  = 1;
                        cause = 8 + w;
                    end
                end
            end
            1: begin
                if (exc_ack) begin
                    mode = 2;
                    if (cause >= 8) m_pend[cause-8] = 1'b0;
                end
            end
            default: if (eret) mode = 0;
        endcase
        m_pend  = m_pend | rise;
        m_armed = m_armed | ~irq;
        m_prev  = irq;
`ifdef EXC_IRQ_MASK_EN
        if (mwe) m_mask = mwd;
`endif
    endtask

    function automatic obs_t expect_now();
        obs_t o;
        o = '0;
        if (reset_n) begin
            o.exc = (mode == 1);
            o.est = (mode == 0) ? 4'd0 : 4'(cause);
            if (mode == 1 && exc_ack && cause >= 8) o.ack[cause-8] = 1'b1;
            o.inh = (mode == 2);
        end
        return o;
    endfunction

    task automatic cyc(input logic [N-1:0] i_irq, input logic i_nai, input logic i_eret,
                       input logic i_ack, input logic i_rst, input logic i_we = 1'b0,
                       input logic [N-1:0] i_wd = '0);
        @(posedge clk);
        model_step();
        #1;
        irq     = i_irq;
        nai     = i_nai;
        eret    = i_eret;
        exc_ack = i_ack;
        reset_n = i_rst;
        mwe     = i_we;
        mwd     = i_wd;
        if (!i_rst) model_reset();
        sb.push_back(expect_now());
    endtask

    task automatic idle(input logic [N-1:0] i_irq, input int n);
        for (int k = 0; k < n; k++) cyc(i_irq, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: every cycle the DUT presents one output vector to compare.
    always @(negedge clk) begin
        obs_t e, a;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            a = '{exc: exc, est: estatus, ack: irq_ack, inh: in_handler};
            total++;
            if (a !== e)
                $display("FAIL outputs t=%0t got exc=%b est=%b ack=%b inh=%b want exc=%b est=%b ack=%b inh=%b",
                         $time, a.exc, a.est, a.ack, a.inh, e.exc, e.est, e.ack, e.inh);
            else
                passed++;
        end
    end

    initial begin
        logic [N-1:0] r_irq;
        int rst_hold;
        irq = '0; nai = 0; eret = 0; exc_ack = 0; reset_n = 0; mwe = 0; mwd = '0;
        model_reset();
        for (int k = 0; k < 3; k++) cyc('0, 0, 0, 0, 0);
        idle('0, 2);

        // Invalid opcode round trip.
        cyc('0, 1, 0, 0, 1);
        idle('0, 2);
        cyc('0, 0, 0, 1, 1);
        idle('0, 1);
        cyc('0, 0, 1, 0, 1);
        idle('0, 2);

        // irq[2] and irq[1] together: channel 1 first, channel 2 after eret.
        idle(4'b0110, 3);
        cyc(4'b0110, 0, 0, 1, 1);
        cyc(4'b0110, 0, 1, 0, 1);
        idle(4'b0110, 2);
        cyc(4'b0110, 0, 0, 1, 1);
        cyc('0, 0, 1, 0, 1);
        idle('0, 2);

        // No nesting: irq[0] edge and not_an_instr while in handler.
        cyc('0, 1, 0, 0, 1);
        cyc('0, 0, 0, 1, 1);
        cyc(4'b0001, 1, 0, 0, 1);
        cyc(4'b0001, 1, 0, 1, 1);
        idle(4'b0001, 2);
        cyc(4'b0001, 0, 1, 0, 1);
        idle(4'b0001, 2);
        cyc(4'b0001, 0, 0, 1, 1);
        cyc('0, 0, 1, 0, 1);
        idle('0, 2);

        // New edge on the acked channel in the ack cycle survives the clear.
        idle(4'b0010, 2);
        idle('0, 1);
        cyc(4'b0010, 0, 0, 1, 1);
        cyc(4'b0010, 0, 1, 0, 1);
        idle(4'b0010, 2);
        cyc(4'b0010, 0, 0, 1, 1);
        cyc('0, 0, 1, 0, 1);
        idle('0, 2);

        // Reset while requesting with channels 0 and 2 pending; irq held through release.
        idle(4'b0101, 3);
        cyc(4'b0101, 0, 0, 0, 0);
        cyc(4'b0101, 0, 0, 0, 0);
        idle(4'b0101, 5);
        idle('0, 2);

`ifdef EXC_IRQ_MASK_EN
        cyc('0, 0, 0, 0, 1, 1'b1, 4'b1110);
        idle(4'b0001, 4);
        cyc(4'b0001, 0, 0, 0, 1, 1'b1, 4'b1111);
        idle(4'b0001, 2);
        cyc(4'b0001, 0, 0, 1, 1);
        cyc('0, 0, 1, 0, 1);
        idle('0, 2);
`endif

        r_irq = '0;
        rst_hold = 0;
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < N; c++) if ($urandom_range(7) == 0) r_irq[c] = ~r_irq[c];
            if (rst_hold == 0 && $urandom_range(199) == 0) rst_hold = $urandom_range(2, 1);
            cyc(r_irq, $urandom_range(9) == 0, $urandom_range(3) == 0, $urandom_range(2) == 0,
                rst_hold == 0, $urandom_range(19) == 0, N'($urandom));
            if (rst_hold > 0) rst_hold--;
        end

        #20;
        total++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
